// File: rtl/memory_stage.sv
// MEM stage: 16-bit data memory, multi-word PC/flags stack push/pop, registered MEM/WB buffer.
// Optional bound check on the upper address bits is enabled by defining MEM_BOUND_CHECK_EN.
module memory_stage #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MR_In,
    input  logic        MW_In,
    input  logic        WB_In,
    input  logic        JWSP_In,
    input  logic        Stack_PC_In,
    input  logic        Stack_Flags_In,
    input  logic [2:0]  WB_Address_In,
    input  logic [31:0] Data_In,
    input  logic [31:0] Address_In,
    input  logic [2:0]  Final_Flags_In,
    output logic        Mem_Stall,
    output logic        WB_Out,
    output logic [2:0]  WB_Address_Out,
    output logic        MR_Out,
    output logic [15:0] Mem_Data_Out,
    output logic [15:0] ALU_Data_Out,
    output logic        PC_Valid,
    output logic [31:0] PC_From_Memory,
    output logic        Flags_Valid,
    output logic [2:0]  Flags_From_Memory,
    output logic        Mem_Error
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StW1, StW2} state_t;
    state_t state_q;

    logic [15:0]       mem [DEPTH];
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        ff_q, wba_q, fl_q;
    logic [15:0]       lo_q;
    logic              mr_q, mw_q, wb_q, jwsp_q, sf_q, err_q;

    logic              idle, in_err, c_mr, c_mw, c_wb, c_jwsp, c_sf, c_err, c_multi, last;
    logic [2:0]        c_wba, c_ff;
    logic [31:0]       c_data;
    logic [ADDR_W-1:0] c_addr, step, mem_addr;
    logic [15:0]       mem_wdata, rd;
    logic              mem_we;

`ifdef MEM_BOUND_CHECK_EN
    assign in_err = |Address_In[31:ADDR_W];
`else
    logic unused_addr_hi;
    assign in_err = 1'b0;
    assign unused_addr_hi = ^Address_In[31:ADDR_W];
`endif

    // In IDLE the live inputs describe cycle 0; afterwards the latched copy is used.
    always_comb begin
        idle    = (state_q == StIdle);
        c_mw    = idle ? MW_In : mw_q;
        c_mr    = idle ? (MR_In && !MW_In) : mr_q;
        c_wb    = idle ? WB_In : wb_q;
        c_jwsp  = idle ? JWSP_In : jwsp_q;
        c_sf    = idle ? Stack_Flags_In : sf_q;
        c_wba   = idle ? WB_Address_In : wba_q;
        c_ff    = idle ? Final_Flags_In : ff_q;
        c_data  = idle ? Data_In : data_q;
        c_addr  = idle ? Address_In[ADDR_W-1:0] : addr_q;
        c_err   = idle ? in_err : err_q;
        c_multi = idle ? (Stack_PC_In && (MR_In || MW_In)) : 1'b1;
        last    = !c_multi || (state_q == StW2) || (state_q == StW1 && !c_sf);
        step    = (state_q == StW2) ? ADDR_W'(2) : (state_q == StW1) ? ADDR_W'(1) : '0;
        // Push grows downward, pop reads upward from the given address.
        mem_addr = c_mw ? (c_addr - step) : (c_addr + step);
        mem_wdata = c_sf ? {13'b0, c_ff} : c_data[15:0];
        if (c_multi) begin
            unique case (state_q)
                StIdle:  mem_wdata = c_data[31:16];
                StW1:    mem_wdata = c_data[15:0];
                default: mem_wdata = {13'b0, c_ff};
            endcase
        end
        mem_we = c_mw && !c_err && !rst;
        rd     = c_err ? 16'h0 : mem[mem_addr];
    end

    assign Mem_Stall = !rst && c_multi && !last;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            data_q            <= '0;
            addr_q            <= '0;
            ff_q              <= '0;
            wba_q             <= '0;
            fl_q              <= '0;
            lo_q              <= '0;
            {mr_q, mw_q, wb_q, jwsp_q, sf_q, err_q} <= '0;
            WB_Out            <= 1'b0;
            WB_Address_Out    <= '0;
            MR_Out            <= 1'b0;
            Mem_Data_Out      <= '0;
            ALU_Data_Out      <= '0;
            PC_Valid          <= 1'b0;
            PC_From_Memory    <= '0;
            Flags_Valid       <= 1'b0;
            Flags_From_Memory <= '0;
            Mem_Error         <= 1'b0;
        end else begin
            PC_Valid    <= 1'b0;
            Flags_Valid <= 1'b0;
            Mem_Error   <= 1'b0;
            if (idle) begin
                data_q <= Data_In;
                addr_q <= Address_In[ADDR_W-1:0];
                ff_q   <= Final_Flags_In;
                wba_q  <= WB_Address_In;
                mr_q   <= MR_In && !MW_In;
                mw_q   <= MW_In;
                wb_q   <= WB_In;
                jwsp_q <= JWSP_In;
                sf_q   <= Stack_Flags_In;
                err_q  <= in_err;
            end
            unique case (state_q)
                StIdle:  if (c_multi) state_q <= StW1;
                StW1:    state_q <= c_sf ? StW2 : StIdle;
                default: state_q <= StIdle;
            endcase
            if (c_multi && c_mr && !last) begin
                if (c_sf && idle) fl_q <= rd[2:0];
                else              lo_q <= rd;
            end
            if (last) begin
                WB_Out         <= c_wb && !c_err;
                WB_Address_Out <= c_wba;
                MR_Out         <= c_mr;
                ALU_Data_Out   <= c_data[15:0];
                Mem_Error      <= c_err;
                if (c_mr) begin
                    // For a pop the last word read (PC high half) appears on Mem_Data_Out.
                    Mem_Data_Out <= rd;
                    if (c_multi) begin
                        PC_From_Memory <= {rd, lo_q};
                        PC_Valid       <= c_jwsp;
                        if (c_sf) begin
                            Flags_From_Memory <= fl_q;
                            Flags_Valid       <= 1'b1;
                        end
                    end else if (c_sf) begin
                        Flags_From_Memory <= rd[2:0];
                        Flags_Valid       <= 1'b1;
                    end
                end
            end else begin
                WB_Out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus random ops against an
// operation-level model of the memory and the MEM/WB outputs.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst, MR_In, MW_In, WB_In, JWSP_In, Stack_PC_In, Stack_Flags_In;
    logic [2:0]  WB_Address_In, Final_Flags_In;
    logic [31:0] Data_In, Address_In;
    logic        Mem_Stall, WB_Out, MR_Out, PC_Valid, Flags_Valid, Mem_Error;
    logic [2:0]  WB_Address_Out, Flags_From_Memory;
    logic [15:0] Mem_Data_Out, ALU_Data_Out;
    logic [31:0] PC_From_Memory;

    memory_stage #(.ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .MR_In(MR_In), .MW_In(MW_In), .WB_In(WB_In), .JWSP_In(JWSP_In),
        .Stack_PC_In(Stack_PC_In), .Stack_Flags_In(Stack_Flags_In),
        .WB_Address_In(WB_Address_In), .Data_In(Data_In), .Address_In(Address_In),
        .Final_Flags_In(Final_Flags_In), .Mem_Stall(Mem_Stall), .WB_Out(WB_Out),
        .WB_Address_Out(WB_Address_Out), .MR_Out(MR_Out), .Mem_Data_Out(Mem_Data_Out),
        .ALU_Data_Out(ALU_Data_Out), .PC_Valid(PC_Valid), .PC_From_Memory(PC_From_Memory),
        .Flags_Valid(Flags_Valid), .Flags_From_Memory(Flags_From_Memory), .Mem_Error(Mem_Error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] ref_mem [4096];
    logic        exp_wb, exp_mr, exp_pv, exp_fv, exp_err;
    logic [2:0]  exp_wba, exp_fl;
    logic [15:0] exp_md, exp_alu;
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".WB_Out"}, WB_Out, exp_wb);
        chk({tag, ".WB_Address_Out"}, WB_Address_Out, exp_wba);
        chk({tag, ".MR_Out"}, MR_Out, exp_mr);
        chk({tag, ".Mem_Data_Out"}, Mem_Data_Out, exp_md);
        chk({tag, ".ALU_Data_Out"}, ALU_Data_Out, exp_alu);
        chk({tag, ".PC_Valid"}, PC_Valid, exp_pv);
        chk({tag, ".PC_From_Memory"}, PC_From_Memory, exp_pc);
        chk({tag, ".Flags_Valid"}, Flags_Valid, exp_fv);
        chk({tag, ".Flags_From_Memory"}, Flags_From_Memory, exp_fl);
        chk({tag, ".Mem_Error"}, Mem_Error, exp_err);
    endtask

    task automatic drive(input bit mr, mw, wb, jwsp, spc, sf, input logic [2:0] wba,
                         input logic [31:0] data, addr, input logic [2:0] ff);
        MR_In = mr; MW_In = mw; WB_In = wb; JWSP_In = jwsp; Stack_PC_In = spc;
        Stack_Flags_In = sf; WB_Address_In = wba; Data_In = data; Address_In = addr;
        Final_Flags_In = ff;
    endtask

    // Called at a negedge; returns at the negedge after the op's final edge, outputs checked.
    task automatic run_op(input string tag, input bit mr, mw, wb, jwsp, spc, sf,
                          input logic [2:0] wba, input logic [31:0] data, addr,
                          input logic [2:0] ff);
        logic [11:0] a, ap1, ap2, am1, am2;
        logic [15:0] lo, hi, fw;
        bit          err, multi, emr;
        int          n;
        a = addr[11:0]; ap1 = a + 12'd1; ap2 = a + 12'd2; am1 = a - 12'd1; am2 = a - 12'd2;
`ifdef MEM_BOUND_CHECK_EN
        err = (addr[31:12] != 20'h0);
`else
        err = 1'b0;
`endif
        multi = spc && (mr || mw);
        emr   = mr && !mw;
        n     = multi ? 2 + int'(sf) : 1;
        exp_wb = wb && !err; exp_wba = wba; exp_mr = emr; exp_alu = data[15:0];
        exp_pv = 1'b0; exp_fv = 1'b0; exp_err = err;
        if (mw) begin
            if (!err) begin
                if (multi) begin
                    ref_mem[a] = data[31:16];
                    ref_mem[am1] = data[15:0];
                    if (sf) ref_mem[am2] = {13'b0, ff};
                end else begin
                    ref_mem[a] = sf ? {13'b0, ff} : data[15:0];
                end
            end
        end else if (mr) begin
            if (multi) begin
                fw = err ? 16'h0 : ref_mem[a];
                lo = err ? 16'h0 : (sf ? ref_mem[ap1] : ref_mem[a]);
                hi = err ? 16'h0 : (sf ? ref_mem[ap2] : ref_mem[ap1]);
                exp_pc = {hi, lo}; exp_pv = jwsp; exp_md = hi;
                if (sf) begin exp_fl = fw[2:0]; exp_fv = 1'b1; end
            end else begin
                fw = err ? 16'h0 : ref_mem[a];
                exp_md = fw;
                if (sf) begin exp_fl = fw[2:0]; exp_fv = 1'b1; end
            end
        end
        drive(mr, mw, wb, jwsp, spc, sf, wba, data, addr, ff);
        #1 chk({tag, ".stall0"}, Mem_Stall, n > 1);
        @(posedge clk);
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            // Inputs must be ignored while a multi-word op is in progress.
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  3'($urandom), $urandom, $urandom, 3'($urandom));
            #1 chk($sformatf("%s.stall%0d", tag, k), Mem_Stall, k < n - 1);
            @(posedge clk);
        end
        @(negedge clk);
        chk_outputs(tag);
    endtask

    task automatic rand_op(input string tag);
        logic [31:0] addr;
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr[31:12] = '0;
        run_op(tag, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               3'($urandom), $urandom, addr, 3'($urandom));
    endtask

    initial begin
        logic [31:0] push_data;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 3'd0);
        {exp_wb, exp_mr, exp_pv, exp_fv, exp_err} = '0;
        exp_wba = '0; exp_fl = '0; exp_md = '0; exp_alu = '0; exp_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs("reset");
        chk("reset.stall", Mem_Stall, 1'b0);
        rst = 1'b0;

        // Fill the whole memory so every later read has a known value.
        for (int i = 0; i < 4096; i++)
            run_op("init", 0, 1, $urandom_range(0, 1), 0, 0, 0, 3'($urandom), $urandom,
                   32'(i), 3'($urandom));

        // Reset in the middle of a three-word push.
        push_data = 32'hA1B2C3D4;
        drive(0, 1, 1, 0, 1, 1, 3'd2, push_data, 32'h200, 3'b011);
        #1 chk("rstmid.stall0", Mem_Stall, 1'b1);
        @(posedge clk);
        ref_mem[12'h200] = push_data[31:16];
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 3'd0);
        #1 chk("rstmid.stall_in_rst", Mem_Stall, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        {exp_wb, exp_mr, exp_pv, exp_fv, exp_err} = '0;
        exp_wba = '0; exp_fl = '0; exp_md = '0; exp_alu = '0; exp_pc = '0;
        chk_outputs("rstmid");
        chk("rstmid.stall", Mem_Stall, 1'b0);
        rst = 1'b0;
        run_op("rstmid.rd200", 1, 0, 1, 0, 0, 0, 3'd1, 32'h0, 32'h200, 3'd0);
        chk("rstmid.word0", Mem_Data_Out, 16'hA1B2);
        run_op("rstmid.rd1ff", 1, 0, 1, 0, 0, 0, 3'd1, 32'h0, 32'h1FF, 3'd0);

        // Single-word store then load.
        run_op("t2.mw", 0, 1, 0, 0, 0, 0, 3'd0, 32'h0000BEEF, 32'h010, 3'd0);
        run_op("t2.mr", 1, 0, 1, 0, 0, 0, 3'd3, 32'h0, 32'h010, 3'd0);
        chk("t2.data", Mem_Data_Out, 16'hBEEF);
        chk("t2.wb", WB_Out, 1'b1);
        chk("t2.mrout", MR_Out, 1'b1);

        // Push PC and flags, then inspect the three words.
        run_op("t3.push", 0, 1, 0, 0, 1, 1, 3'd0, 32'h00012345, 32'h0FF, 3'b101);
        run_op("t3.rd0ff", 1, 0, 1, 0, 0, 0, 3'd4, 32'h0, 32'h0FF, 3'd0);
        chk("t3.w0ff", Mem_Data_Out, 16'h0001);
        run_op("t3.rd0fe", 1, 0, 1, 0, 0, 0, 3'd4, 32'h0, 32'h0FE, 3'd0);
        chk("t3.w0fe", Mem_Data_Out, 16'h2345);
        run_op("t3.rd0fd", 1, 0, 1, 0, 0, 0, 3'd4, 32'h0, 32'h0FD, 3'd0);
        chk("t3.w0fd", Mem_Data_Out, 16'h0005);

        // Pop with flags and JWSP.
        run_op("t4.pop", 1, 0, 0, 1, 1, 1, 3'd0, 32'h0, 32'h0FD, 3'd0);
        chk("t4.pc", PC_From_Memory, 32'h00012345);
        chk("t4.flags", Flags_From_Memory, 3'b101);
        chk("t4.pcv", PC_Valid, 1'b1);
        chk("t4.fv", Flags_Valid, 1'b1);
        run_op("t4.after", 0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 3'd0);
        chk("t4.pcv_drop", PC_Valid, 1'b0);

        // Address wrap around both ends of memory.
        run_op("t5.push", 0, 1, 0, 0, 1, 0, 3'd0, 32'hCAFE1234, 32'h000, 3'd0);
        run_op("t5.pop", 1, 0, 0, 1, 1, 0, 3'd0, 32'h0, 32'hFFF, 3'd0);
        chk("t5.pc", PC_From_Memory, 32'hCAFE1234);

        // Upper address bits set.
        run_op("t6.mw", 0, 1, 1, 0, 0, 0, 3'd0, 32'h00005555, 32'h00010010, 3'd0);
        run_op("t6.mr", 1, 0, 1, 0, 0, 0, 3'd5, 32'h0, 32'h010, 3'd0);
`ifdef MEM_BOUND_CHECK_EN
        chk("t6.data", Mem_Data_Out, 16'hBEEF);
`else
        chk("t6.data", Mem_Data_Out, 16'h5555);
`endif

        for (int i = 0; i < 400; i++) rand_op($sformatf("rnd%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
